// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if
// Bundles the in-pipeline data SRAM-like handshake between the execute stage
// (master) and the data memory responder (slave).
//   data_sram_req/wr/size/wstrb/addr/wdata : request phase, master -> slave
//   data_sram_addr_ok                       : request accepted this cycle
//   data_sram_data_ok/rdata                 : response pulse and read data
//   addr_stall                              : test hook forcing addr_ok low
interface data_sram_resp_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        addr_stall;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata, addr_stall,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata, addr_stall,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_resp.sv
// data_sram_resp
// Responder for the data SRAM-like interface: word-organised backing store
// with a fixed-latency, in-order response FIFO supporting up to QDEPTH
// outstanding requests.
//   clk   : single clock
//   reset : synchronous, active-high; drops all pending responses
//   bus   : data_sram_resp_if slave modport (request, addr_ok, data_ok, rdata,
//           addr_stall test hook)
// Parameters: ADDR_W word-index width (2^ADDR_W words), LATENCY 1..15 cycles
// from acceptance to data_ok, QDEPTH 1..8 outstanding entries.
module data_sram_resp #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic             clk,
  input  logic             reset,
  data_sram_resp_if.slave  bus
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [31:0]       mem [1 << ADDR_W];
  logic [ADDR_W-1:0] widx;

  logic [3:0]        count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              q_is_rd [QDEPTH];
  logic [31:0]       q_data  [QDEPTH];
  logic [3:0]        q_cnt   [QDEPTH];

  logic              accept;
  logic              pop;
  logic              data_ok_q;
  logic [31:0]       rdata_q;

  // Size and the address bits outside the word index are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_W+2],
                         bus.data_sram_addr[1:0]};

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign widx = bus.data_sram_addr[ADDR_W+1:2];

  // A pop in the same cycle does not open a slot: the limit uses registered count.
  assign bus.data_sram_addr_ok = bus.data_sram_req & ~reset & ~bus.addr_stall &
                                 (count < 4'(QDEPTH));
  assign accept = bus.data_sram_req & bus.data_sram_addr_ok;
  assign pop    = (count != '0) & (q_cnt[rd_ptr] == '0);

  assign bus.data_sram_data_ok = data_ok_q;
  assign bus.data_sram_rdata   = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (pop)    rd_ptr <= next_ptr(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      data_ok_q <= pop;
      rdata_q   <= (pop && q_is_rd[rd_ptr]) ? q_data[rd_ptr] : '0;
    end
  end

  // Latency counters: free slots also count down, harmless since a push reloads.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (reset) begin
        q_cnt[i] <= '0;
      end else if (accept && (wr_ptr == PW'(i))) begin
        q_cnt[i] <= 4'(LATENCY - 1);
      end else if (q_cnt[i] != '0) begin
        q_cnt[i] <= q_cnt[i] - 4'd1;
      end
    end
  end

  // Backing store and read snapshot; the snapshot sees the pre-edge contents,
  // which already include every write accepted at an earlier edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bus.data_sram_wr) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (bus.data_sram_wstrb[b]) mem[widx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
        end
      end
      q_is_rd[wr_ptr] <= ~bus.data_sram_wr;
      q_data[wr_ptr]  <= bus.data_sram_wr ? '0 : mem[widx];
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp
// Directed bench for data_sram_resp at default parameters (ADDR_W=10,
// LATENCY=2, QDEPTH=2). Responses are logged with the cycle they appear in and
// compared against hand-computed cycle offsets and data.
module tb_data_sram_resp;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  int          resp_cyc [$];
  logic [31:0] resp_dat [$];

  data_sram_resp_if bus ();

  data_sram_resp #(
    .ADDR_W  (10),
    .LATENCY (2),
    .QDEPTH  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response logger; rdata must be zero whenever data_ok is low.
  always @(negedge clk) begin
    if (bus.data_sram_data_ok === 1'b1) begin
      resp_cyc.push_back(cyc);
      resp_dat.push_back(bus.data_sram_rdata);
    end else begin
      chk("rdata_idle", bus.data_sram_rdata, 32'h0);
    end
  end

  // Present a request and hold it until accepted; acc is the negedge sample
  // index of the accepting cycle. Returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output int acc, output int waited);
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = wr;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    bus.data_sram_wstrb = wstrb;
    acc    = -1;
    waited = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.data_sram_addr_ok === 1'b1) begin
        acc = cyc;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    if (acc < 0) chk("accept_timeout", 32'h0, 32'h1);
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    bus.data_sram_req = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_resp(input string tag, input int exp_cyc, input logic [31:0] exp_dat);
    int          c;
    logic [31:0] d;
    if (resp_cyc.size() == 0) begin
      chk({tag, "_missing"}, 32'h0, 32'h1);
    end else begin
      c = resp_cyc.pop_front();
      d = resp_dat.pop_front();
      chk({tag, "_cyc"}, 32'(c), 32'(exp_cyc));
      chk({tag, "_data"}, d, exp_dat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, aw, ar, a1, a2, a3, w;
    n_tests = 0;
    n_fail  = 0;

    // Reset held 3 cycles with a no-op write (wstrb=0) requested throughout.
    reset               = 1'b1;
    bus.addr_stall      = 1'b0;
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = 1'b1;
    bus.data_sram_size  = 2'd2;
    bus.data_sram_wstrb = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_addr_ok", 32'(bus.data_sram_addr_ok), 32'h0);
      chk("rst_data_ok", 32'(bus.data_sram_data_ok), 32'h0);
      chk("rst_rdata",   bus.data_sram_rdata, 32'h0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_addr_ok", 32'(bus.data_sram_addr_ok), 32'h1);
    a0 = cyc;
    @(posedge clk); #1;
    idle();
    wait_cycles(5);
    expect_resp("nop_wr", a0 + 3, 32'h0);

    // Word write then read, back to back.
    issue(1'b1, 32'h10, 32'h1234_5678, 4'hF, aw, w);
    issue(1'b0, 32'h10, 32'h0, 4'h0, ar, w);
    idle();
    chk("s2_b2b", 32'(ar - aw), 32'h1);
    wait_cycles(6);
    expect_resp("s2_wr", aw + 3, 32'h0);
    expect_resp("s2_rd", aw + 4, 32'h1234_5678);

    // Single byte lane 2 write, read via an unaligned address in the same word.
    issue(1'b1, 32'h10, 32'hAAAA_AAAA, 4'b0100, aw, w);
    issue(1'b0, 32'h12, 32'h0, 4'h0, ar, w);
    idle();
    wait_cycles(6);
    expect_resp("s3_wr", aw + 3, 32'h0);
    expect_resp("s3_rd", aw + 4, 32'h12AA_5678);

    // Full queue: three back-to-back reads of distinct words.
    issue(1'b1, 32'h20, 32'h1111_1111, 4'hF, aw, w);
    issue(1'b1, 32'h24, 32'h2222_2222, 4'hF, ar, w);
    idle();
    wait_cycles(6);
    expect_resp("s4_wr0", aw + 3, 32'h0);
    expect_resp("s4_wr1", aw + 4, 32'h0);
    issue(1'b0, 32'h10, 32'h0, 4'h0, a1, w);
    issue(1'b0, 32'h20, 32'h0, 4'h0, a2, w);
    issue(1'b0, 32'h24, 32'h0, 4'h0, a3, w);
    idle();
    chk("s4_acc2", 32'(a2 - a1), 32'h1);
    chk("s4_acc3", 32'(a3 - a1), 32'h3);
    chk("s4_full_wait", 32'(w), 32'h1);
    wait_cycles(8);
    expect_resp("s4_rd0", a1 + 3, 32'h12AA_5678);
    expect_resp("s4_rd1", a1 + 4, 32'h1111_1111);
    expect_resp("s4_rd2", a1 + 6, 32'h2222_2222);
    chk("s4_no_extra", 32'(resp_cyc.size()), 32'h0);

    // Stall: four cycles of request with no acceptance.
    bus.addr_stall      = 1'b1;
    bus.data_sram_req   = 1'b1;
    bus.data_sram_wr    = 1'b0;
    bus.data_sram_addr  = 32'h10;
    repeat (4) begin
      @(negedge clk);
      chk("stall_addr_ok", 32'(bus.data_sram_addr_ok), 32'h0);
      @(posedge clk); #1;
    end
    bus.addr_stall = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0, ar, w);
    chk("unstall_wait", 32'(w), 32'h0);
    idle();
    @(posedge clk); #1;
    reset             = 1'b1;
    bus.data_sram_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_addr_ok", 32'(bus.data_sram_addr_ok), 32'h0);
    chk("midrst_data_ok", 32'(bus.data_sram_data_ok), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    wait_cycles(8);
    chk("midrst_dropped", 32'(resp_cyc.size()), 32'h0);

    // Aliasing: bits above the word index are ignored.
    issue(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, aw, w);
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, ar, w);
    idle();
    wait_cycles(6);
    expect_resp("alias_wr", aw + 3, 32'h0);
    expect_resp("alias_rd", aw + 4, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
